// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the MIPS pipeline: 32-step shift-add multiply and restoring divide,
// plus MTHI/MTLO writes from Writeback. Results land in hi/lo 33 edges after start.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [1:0]       dbg_state_o
);

    // Handshake: start is taken on a rising edge where start=1 and busy=0; operands are
    // captured then and never re-sampled. done pulses for one cycle when hi/lo update.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               zero_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mq_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic               div_zero_q;

    logic               op_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_signed = ~op[0];
    assign abs_a     = (op_signed && srcA[WIDTH-1]) ? -srcA : srcA;
    assign abs_b     = (op_signed && srcB[WIDTH-1]) ? -srcB : srcB;

    // acc holds the product high half (multiply) or the partial remainder (divide);
    // mq holds the multiplier / dividend and fills with product low bits / quotient bits.
    assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
    assign div_shift = {acc_q, mq_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mcand_q};
    assign div_ok    = ~div_trial[WIDTH];

    assign prod      = {acc_q, mq_q};
    assign prod_fix  = neg_res_q ? -prod : prod;
    assign quo_fix   = neg_res_q ? -mq_q : mq_q;
    assign rem_fix   = neg_rem_q ? -acc_q : acc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            mcand_q    <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mthi) hi_q <= wdata;
                    if (mtlo) lo_q <= wdata;
                    if (start) begin
                        is_div_q   <= op[1];
                        neg_res_q  <= op_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        neg_rem_q  <= op_signed && srcA[WIDTH-1];
                        zero_q     <= (srcB == '0);
                        mcand_q    <= op[1] ? abs_b : abs_a;
                        mq_q       <= op[1] ? abs_a : abs_b;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        div_zero_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        acc_q <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        mq_q  <= {mq_q[WIDTH-2:0], div_ok};
                    end else begin
                        {acc_q, mq_q} <= {mul_sum, mq_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    done_q <= 1'b1;
                    cnt_q  <= '0;
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else if (zero_q) begin
                        div_zero_q <= 1'b1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign divZero     = div_zero_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: transaction-level HI/LO model with a per-cycle compare,
// plus directed operations with hand-computed results and latency checks.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi, lo;
    logic        busy, done, divZero;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .divZero(divZero),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {hi, lo} for a completed operation, straight from the ISA rules.
    function automatic logic [63:0] calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (o)
            2'd0: res = sa * sb;
            2'd1: res = ua * ub;
            2'd2: begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            default: res = {32'(ua % ub), 32'(ua / ub)};
        endcase
        return res;
    endfunction

    // Model: an accepted start fixes the result now and publishes it 33 edges later.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    if (p_dz) m_dz = 1'b1;
                    else begin
                        m_hi = p_hi;
                        m_lo = p_lo;
                    end
                end
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
                if (start) begin
                    p_dz = op[1] && (srcB == 32'd0);
                    if (!p_dz) begin
                        m_res = calc(op, srcA, srcB);
                        p_hi = m_res[63:32];
                        p_lo = m_res[31:0];
                    end
                    m_dz = 1'b0;
                    m_left = 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
            check("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
            check("cyc_busy", {63'd0, busy}, {63'd0, m_left > 0});
            check("cyc_done", {63'd0, done}, {63'd0, m_done});
            if (m_done) check("cyc_divzero", {63'd0, divZero}, {63'd0, m_dz});
        end
    end

    // Launches at the current time, then waits for done. poke_at pulses start/mthi/mtlo
    // with junk mid-run; mt_too issues MTHI+MTLO in the same cycle as start.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input bit mt_too,
                          output int lat, output int busy_cyc);
        op = o; srcA = a; srcB = b; start = 1'b1;
        if (mt_too) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA5555; end
        lat = 0;
        busy_cyc = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
                op = 2'($urandom_range(0, 3)); srcA = $urandom; srcB = $urandom;
            end
            if (lat == poke_at) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
            end
            if (lat == poke_at + 1) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            if (busy) busy_cyc++;
            if (done) break;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic expect_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        check({name, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check({name, "_lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    initial begin
        int lat, bcyc, pulses;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        expect_hilo("reset", 32'h0, 32'h0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_divzero", {63'd0, divZero}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset around iteration 10 of a multiply.
        op = 2'd1; srcA = 32'h1111; srcB = 32'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        expect_hilo("midrun_reset", 32'h0, 32'h0);
        check("midrun_reset_busy", {63'd0, busy}, 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrun_reset_no_done", 64'(pulses), 64'd0);

        run_op(2'd1, 32'd2, 32'd3, -1, 1'b0, lat, bcyc);
        expect_hilo("multu_2x3", 32'h0, 32'h6);

        run_op(2'd0, 32'hFFFFFFFD, 32'd5, -1, 1'b0, lat, bcyc);
        expect_hilo("mult_m3x5", 32'hFFFFFFFF, 32'hFFFFFFF1);
        check("mult_latency", 64'(lat - 1), 64'd33);
        check("mult_busy_cycles", 64'(bcyc), 64'd33);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);

        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0, lat, bcyc);
        expect_hilo("multu_max", 32'hFFFFFFFE, 32'h00000001);

        run_op(2'd2, 32'hFFFFFFF9, 32'd2, -1, 1'b0, lat, bcyc);
        expect_hilo("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);

        run_op(2'd3, 32'd100, 32'd7, -1, 1'b1, lat, bcyc);
        expect_hilo("divu_100_7", 32'h00000002, 32'h0000000E);
        check("divu_divzero", {63'd0, divZero}, 64'd0);

        run_op(2'd2, 32'd7, 32'hFFFFFFFE, -1, 1'b0, lat, bcyc);
        expect_hilo("div_7_m2", 32'h00000001, 32'hFFFFFFFD);

        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        mtlo = 1'b0;
        expect_hilo("mt_preload", 32'h1234, 32'h5678);

        run_op(2'd3, 32'd9, 32'd0, 5, 1'b0, lat, bcyc);
        expect_hilo("divu_by_zero", 32'h1234, 32'h5678);
        check("divu_by_zero_flag", {63'd0, divZero}, 64'd1);

        // Issued in the done cycle of the previous operation.
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0, lat, bcyc);
        expect_hilo("div_overflow", 32'h0, 32'h80000000);
        check("b2b_latency", 64'(lat - 1), 64'd33);
        check("divzero_cleared", {63'd0, divZero}, 64'd0);

        run_op(2'd0, 32'h7FFFFFFF, 32'h80000000, 12, 1'b0, lat, bcyc);
        expect_hilo("mult_extreme", 32'hC0000000, 32'h80000000);
        check("busy_start_ignored_latency", 64'(lat - 1), 64'd33);

        repeat (3) @(negedge clk);
        check("idle_at_end", {63'd0, busy}, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the architectural HI and LO registers of the MIPS pipeline.
- It is the writer side of the HI/LO path. It accepts MULT/MULTU/DIV/DIVU from the Execute stage and MTHI/MTLO writes from Writeback.
- It publishes registered HI/LO values, plus busy/done status, to the hazard unit and the HI/LO forwarding muxer.
- Each operation uses a 32-step shift-add (multiply) or restoring (divide) datapath.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low.
- start  input  1  launch an operation; sampled only while busy=0.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcA  input  WIDTH  rs operand (multiplicand or dividend).
- srcB  input  WIDTH  rt operand (multiplier or divisor).
- mthi  input  1  write HI from wdata.
- mtlo  input  1  write LO from wdata.
- wdata  input  WIDTH  MTHI/MTLO data.
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.
- busy  output  1  operation in progress; the hazard unit stalls MFHI/MFLO/MTHI/MTLO and a new mult/div while it is high.
- done  output  1  one-cycle pulse in the cycle HI/LO first show a new result.
- divZero  output  1  registered flag, valid while done=1: last divide had srcB=0.

Behaviour:
- Reset (asynchronous, reset_n=0): hi=0, lo=0, busy=0, done=0, divZero=0, state=IDLE, counter=0. Any operation in flight is abandoned; no partial result reaches hi/lo.
- State IDLE, start=1 at edge E0:
  - capture op, operand magnitudes (absolute value for signed ops) and result sign flags;
  - go to RUN with counter=0; busy=1 from after E0.
- State RUN: one iteration per cycle; counter increments; after iteration 31 (edge E32) go to FIX.
  - Multiply: 64-bit product accumulates in the {acc, multiplier} shift pair.
  - Divide: restoring step. Shift {rem, quo} left, trial-subtract the divisor, keep the result if it is non-negative and set the quotient bit.
- State FIX (edge E33):
  - apply two's-complement sign correction;
  - write hi/lo; pulse done=1 for the following cycle;
  - busy=0 after E33; return to IDLE.
  - Total latency: start edge to new hi/lo = 33 cycles. A new start is accepted in the cycle done=1.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = full 64-bit signed/unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned lo = quotient, hi = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps, no trap).
- Divide by zero: the full 33-cycle sequence still runs. hi/lo are left unchanged, divZero=1 alongside done. divZero clears on the next start.
- MTHI/MTLO:
  - Take effect at the next edge only when busy=0.
  - Ignored while busy=1; the hazard unit guarantees they do not occur then.
  - Both asserted in the same cycle: both registers are written with wdata.
- Simultaneous start with mthi/mtlo in IDLE: the mt write occurs and the operation launches; the completion at E33 overwrites both hi and lo.
- start while busy=1: ignored; no queuing.
- op and operands need only be valid in the start cycle; they are not re-sampled.

Test Plan:
- Reset: assert reset_n=0 mid-RUN (iteration 10), release -> hi=lo=0, busy=0, done never pulses; next MULTU 2*3 gives lo=6, hi=0.
- MULT srcA=0xFFFFFFFD (-3), srcB=5 -> after exactly 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1; done high one cycle; busy high for cycles 1..33.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- DIVU with srcB=0, hi/lo preloaded by MTHI=0x1234, MTLO=0x5678 -> done with divZero=1, hi=0x1234, lo=0x5678 unchanged.
- Back-to-back and boundary operations:
  - start asserted again in the done cycle -> accepted;
  - mthi pulsed while busy -> ignored;
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
